// File: rtl/switch_alloc_rr.sv
// switch_alloc_rr: N-port switch allocator with per-output round-robin arbiters and a registered crossbar.
// Define SA_STATS_EN to add saturating per-output grant counters (stats_clr, grant_cnt).
module switch_alloc_rr #(
    parameter int NUM_PORTS = 5,
    parameter int DATASIZE  = 40,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] label_in,
    input  logic [NUM_PORTS*DATASIZE-1:0]  data_in,
    input  logic [NUM_PORTS-1:0]           out_full,
    output logic [NUM_PORTS-1:0]           in_ready,
    output logic [NUM_PORTS-1:0]           data_valid,
    output logic [NUM_PORTS*DATASIZE-1:0]  data_out
`ifdef SA_STATS_EN
    ,
    input  logic                           stats_clr,
    output logic [NUM_PORTS*CNT_W-1:0]     grant_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]           req_san [NUM_PORTS];
    logic [NUM_PORTS*NUM_PORTS-1:0] grant_flat;

    // Keep only the lowest set label bit so every input targets at most one output.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_san
        logic [NUM_PORTS-1:0] lbl;
        assign lbl         = label_in[gi*NUM_PORTS +: NUM_PORTS];
        assign req_san[gi] = lbl & (~lbl + NUM_PORTS'(1));
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
        logic [NUM_PORTS-1:0] req_col;
        logic [NUM_PORTS-1:0] grant_vec;
        logic [PTR_W-1:0]     grant_idx;
        logic [PTR_W-1:0]     ptr_reg;
        logic                 grant_any;
        logic [DATASIZE-1:0]  grant_data;
        logic [DATASIZE-1:0]  dout_reg;
        logic                 dvalid_reg;

        always_comb begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_col[i] = req_san[i][gi];
            end
        end

        // Search starts one past the last winner, wrapping at NUM_PORTS.
        always_comb begin
            int               idx;
            logic [PTR_W-1:0] sel;
            grant_vec = '0;
            grant_idx = ptr_reg;
            grant_any = 1'b0;
            idx       = 0;
            sel       = '0;
            if (!out_full[gi]) begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    idx = int'(ptr_reg) + k;
                    if (idx >= NUM_PORTS) begin
                        idx = idx - NUM_PORTS;
                    end
                    sel = PTR_W'(idx);
                    if (!grant_any && req_col[sel]) begin
                        grant_any      = 1'b1;
                        grant_idx      = sel;
                        grant_vec[sel] = 1'b1;
                    end
                end
            end
        end

        assign grant_data = data_in[grant_idx*DATASIZE +: DATASIZE];
        assign grant_flat[gi*NUM_PORTS +: NUM_PORTS] = grant_vec;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ptr_reg    <= PTR_W'(NUM_PORTS - 1);
                dvalid_reg <= 1'b0;
                dout_reg   <= '0;
            end else begin
                dvalid_reg <= grant_any;
                if (grant_any) begin
                    ptr_reg  <= grant_idx;
                    dout_reg <= grant_data;
                end
            end
        end

        assign data_valid[gi]                    = dvalid_reg;
        assign data_out[gi*DATASIZE +: DATASIZE] = dout_reg;

`ifdef SA_STATS_EN
        logic [CNT_W-1:0] cnt_reg;

        // Clear wins over increment; the counter sticks at all-ones.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (stats_clr) begin
                cnt_reg <= '0;
            end else if (grant_any && (cnt_reg != '1)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end

        assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
    end

    always_comb begin
        in_ready = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                in_ready[i] = in_ready[i] | grant_flat[o*NUM_PORTS + i];
            end
        end
    end

endmodule
